// File: rtl/orion_mem_arbiter.sv
// orion_mem_arbiter: shares one downstream memory port between the core's
// instruction-fetch (imem) and data (dmem) ports.
//
// Handshake contract (all ports):
//   Upstream: the requester raises x_valid_i with its request fields and holds
//   them until x_resp_o pulses high for exactly one cycle. x_rdata_o is only
//   meaningful while x_resp_o=1 and reads 0 otherwise.
//   Downstream: mem_valid_o and every mem_*_o field are registered, raised the
//   cycle after a grant and held stable until the cycle in which mem_resp_i=1.
//   That response is forwarded combinationally to the owning upstream port in
//   the same cycle. Only one transaction is ever outstanding.

package orion_types;
  localparam int ADDRW = 32;
  localparam int XLEN  = 32;
  localparam int MASKW = 4;
endpackage

module orion_mem_arbiter
  import orion_types::*;
#(
  parameter int ARB_MODE       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // instruction-fetch port (read only)
  input  logic [ADDRW-1:0] imem_addr_i,
  input  logic             imem_valid_i,
  output logic [XLEN-1:0]  imem_rdata_o,
  output logic             imem_resp_o,
  // data port
  input  logic [ADDRW-1:0] dmem_addr_i,
  input  logic [XLEN-1:0]  dmem_wdata_i,
  input  logic [MASKW-1:0] dmem_mask_i,
  input  logic             dmem_we_i,
  input  logic             dmem_valid_i,
  output logic [XLEN-1:0]  dmem_rdata_o,
  output logic             dmem_resp_o,
  // downstream memory port
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  output logic [MASKW-1:0] mem_mask_o,
  output logic             mem_we_o,
  output logic             mem_valid_o,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic             mem_resp_i,
  // sticky watchdog flag
  output logic             timeout_o,
  // FSM state for observation: 0=IDLE, 1=BUSY_I, 2=BUSY_D
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  // The counter only needs to reach TIMEOUT_CYCLES-1, where it saturates.
  localparam int CNTW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             last_d_q, last_d_d;   // 1 = last grant went to dmem
  logic [CNTW-1:0]  wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [MASKW-1:0] mask_q, mask_d;
  logic             we_q, we_d;
  logic             pick_d;               // dmem wins the current arbitration

  // Arbitration: a lone requester wins; a tie goes to D in fixed mode and to
  // the port that did not win last time in round-robin mode.
  always_comb begin
    pick_d = dmem_valid_i;
    if (imem_valid_i && dmem_valid_i) begin
      if (ARB_MODE == 0) begin
        pick_d = 1'b1;
      end else begin
        pick_d = ~last_d_q;
      end
    end
  end

  // Next-state, request latching and watchdog.
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    we_d      = we_q;
    case (state_q)
      IDLE: begin
        // A stray mem_resp_i here has no owner and is dropped.
        wd_cnt_d = '0;
        if (imem_valid_i || dmem_valid_i) begin
          if (pick_d) begin
            state_d  = BUSY_D;
            last_d_d = 1'b1;
            addr_d   = dmem_addr_i;
            wdata_d  = dmem_wdata_i;
            mask_d   = dmem_mask_i;
            we_d     = dmem_we_i;
          end else begin
            state_d  = BUSY_I;
            last_d_d = 1'b0;
            addr_d   = imem_addr_i;
            wdata_d  = '0;
            mask_d   = '1;
            we_d     = 1'b0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        // Upstream inputs are ignored here; a dropped valid does not abort.
        if (mem_resp_i) begin
          state_d  = IDLE;
          wd_cnt_d = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (wd_cnt_q == CNT_LAST) begin
            timeout_d = 1'b1;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers; reset returns to IDLE immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      we_q      <= we_d;
    end
  end

  // Downstream request and zero-latency response return to the owner.
  always_comb begin
    mem_valid_o  = (state_q != IDLE);
    mem_addr_o   = addr_q;
    mem_wdata_o  = wdata_q;
    mem_mask_o   = mask_q;
    mem_we_o     = we_q;
    timeout_o    = timeout_q;
    dbg_state_o  = state_q;
    imem_resp_o  = (state_q == BUSY_I) && mem_resp_i;
    dmem_resp_o  = (state_q == BUSY_D) && mem_resp_i;
    imem_rdata_o = imem_resp_o ? mem_rdata_i : '0;
    dmem_rdata_o = dmem_resp_o ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_orion_mem_arbiter.sv
// Bench for orion_mem_arbiter: round-robin instance (a, watchdog of 8) and a
// fixed-D-priority instance (b); sel routes the shared stimulus to one of them.
module tb_orion_mem_arbiter;
  import orion_types::*;

  localparam int ISSW = 1 + MASKW + XLEN + ADDRW;  // {we, mask, wdata, addr}
  localparam int RSPW = 2 + 2 * XLEN;              // {dresp, iresp, drdata, irdata}
  localparam int CW   = 192;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic             sel        = 1'b0;   // 0 = DUT a, 1 = DUT b
  logic [ADDRW-1:0] imem_addr  = '0;
  logic             imem_valid = 1'b0;
  logic [ADDRW-1:0] dmem_addr  = '0;
  logic [XLEN-1:0]  dmem_wdata = '0;
  logic [MASKW-1:0] dmem_mask  = '0;
  logic             dmem_we    = 1'b0;
  logic             dmem_valid = 1'b0;
  logic [XLEN-1:0]  mem_rdata  = '0;
  logic             mem_resp   = 1'b0;

  // ---------------- DUT outputs ----------------
  logic [XLEN-1:0]  a_irdata, a_drdata, b_irdata, b_drdata;
  logic             a_iresp, a_dresp, b_iresp, b_dresp;
  logic [ADDRW-1:0] a_addr, b_addr;
  logic [XLEN-1:0]  a_wdata, b_wdata;
  logic [MASKW-1:0] a_mask, b_mask;
  logic             a_we, b_we, a_valid, b_valid, a_timeout, b_timeout;
  logic [1:0]       a_dbg, b_dbg;

  orion_mem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_addr_i(imem_addr), .imem_valid_i(imem_valid & ~sel),
    .imem_rdata_o(a_irdata), .imem_resp_o(a_iresp),
    .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata), .dmem_mask_i(dmem_mask),
    .dmem_we_i(dmem_we), .dmem_valid_i(dmem_valid & ~sel),
    .dmem_rdata_o(a_drdata), .dmem_resp_o(a_dresp),
    .mem_addr_o(a_addr), .mem_wdata_o(a_wdata), .mem_mask_o(a_mask),
    .mem_we_o(a_we), .mem_valid_o(a_valid),
    .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp & ~sel),
    .timeout_o(a_timeout), .dbg_state_o(a_dbg)
  );

  orion_mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(1024)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_addr_i(imem_addr), .imem_valid_i(imem_valid & sel),
    .imem_rdata_o(b_irdata), .imem_resp_o(b_iresp),
    .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata), .dmem_mask_i(dmem_mask),
    .dmem_we_i(dmem_we), .dmem_valid_i(dmem_valid & sel),
    .dmem_rdata_o(b_drdata), .dmem_resp_o(b_dresp),
    .mem_addr_o(b_addr), .mem_wdata_o(b_wdata), .mem_mask_o(b_mask),
    .mem_we_o(b_we), .mem_valid_o(b_valid),
    .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp & sel),
    .timeout_o(b_timeout), .dbg_state_o(b_dbg)
  );

  // Outputs of the currently selected DUT.
  logic [XLEN-1:0]  m_irdata, m_drdata, m_wdata;
  logic             m_iresp, m_dresp, m_we, m_valid, m_timeout;
  logic [ADDRW-1:0] m_addr;
  logic [MASKW-1:0] m_mask;
  logic [1:0]       m_dbg;
  assign m_irdata  = sel ? b_irdata  : a_irdata;
  assign m_drdata  = sel ? b_drdata  : a_drdata;
  assign m_iresp   = sel ? b_iresp   : a_iresp;
  assign m_dresp   = sel ? b_dresp   : a_dresp;
  assign m_addr    = sel ? b_addr    : a_addr;
  assign m_wdata   = sel ? b_wdata   : a_wdata;
  assign m_mask    = sel ? b_mask    : a_mask;
  assign m_we      = sel ? b_we      : a_we;
  assign m_valid   = sel ? b_valid   : a_valid;
  assign m_timeout = sel ? b_timeout : a_timeout;
  assign m_dbg     = sel ? b_dbg     : a_dbg;

  // ---------------- scoreboard ----------------
  logic [ISSW-1:0] iss_q[$];
  logic [RSPW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_i(input logic [ADDRW-1:0] a, input logic [XLEN-1:0] rd);
    iss_q.push_back({1'b0, {MASKW{1'b1}}, {XLEN{1'b0}}, a});
    exp_q.push_back({1'b0, 1'b1, {XLEN{1'b0}}, rd});
  endtask

  task automatic push_d(input logic we, input logic [MASKW-1:0] mk, input logic [XLEN-1:0] wd,
                        input logic [ADDRW-1:0] a, input logic [XLEN-1:0] rd);
    iss_q.push_back({we, mk, wd, a});
    exp_q.push_back({1'b1, 1'b0, rd, {XLEN{1'b0}}});
  endtask

  // Memory responder: waits for the issued request, checks it is held for
  // dly cycles, then pulses mem_resp for one cycle with rd and checks the
  // upstream response in that same cycle.
  task automatic serve(input string tag, input int dly, input logic [XLEN-1:0] rd);
    int waited;
    logic [ISSW-1:0] e_iss;
    logic [RSPW-1:0] e_rsp;
    waited = 0;
    while (m_valid !== 1'b1 && waited < 16) begin
      tick();
      waited++;
    end
    check({tag, "_issue"}, CW'(m_valid), CW'(1));
    e_iss = '0;
    e_rsp = '0;
    if (iss_q.size() > 0) e_iss = iss_q.pop_front();
    if (exp_q.size() > 0) e_rsp = exp_q.pop_front();
    for (int k = 0; k < dly; k++) begin
      mem_rdata = $urandom;
      check({tag, "_bus"}, CW'({m_valid, m_we, m_mask, m_wdata, m_addr}), CW'({1'b1, e_iss}));
      check({tag, "_quiet"}, CW'({m_dresp, m_iresp, m_drdata, m_irdata}), CW'(0));
      tick();
    end
    check({tag, "_bus"}, CW'({m_valid, m_we, m_mask, m_wdata, m_addr}), CW'({1'b1, e_iss}));
    mem_resp  = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    check({tag, "_resp"}, CW'({m_dresp, m_iresp, m_drdata, m_irdata}), CW'(e_rsp));
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
    check({tag, "_idle"}, CW'({m_valid, m_iresp, m_dresp}), CW'(0));
  endtask

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL time_limit observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

  initial begin
    logic [ISSW-1:0] wd_iss;

    // ---- reset ----
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", CW'({a_valid, a_we, a_mask, a_wdata, a_addr, a_timeout, a_iresp, a_dresp, a_dbg}), CW'(0));
    check("reset_b", CW'({b_valid, b_we, b_mask, b_wdata, b_addr, b_timeout, b_iresp, b_dresp, b_dbg}), CW'(0));
    rst_n = 1'b1;
    tick();

    // ---- 1: fetch only ----
    imem_addr  = 32'h8000_0000;
    imem_valid = 1'b1;
    push_i(32'h8000_0000, 32'h0000_0013);
    serve("fetch", 3, 32'h0000_0013);
    imem_valid = 1'b0;

    // ---- 2: round-robin tie, both valid continuously ----
    imem_addr  = 32'h0000_0100;
    dmem_addr  = 32'h0000_0200;
    dmem_wdata = 32'h1111_2222;
    dmem_mask  = 4'h5;
    dmem_we    = 1'b0;
    imem_valid = 1'b1;
    dmem_valid = 1'b1;
    push_d(1'b0, 4'h5, 32'h1111_2222, 32'h0000_0200, 32'hD000_0001);
    push_i(32'h0000_0100, 32'h1000_0002);
    push_d(1'b0, 4'h5, 32'h1111_2222, 32'h0000_0200, 32'hD000_0003);
    push_i(32'h0000_0100, 32'h1000_0004);
    serve("rr0", 1, 32'hD000_0001);
    serve("rr1", 1, 32'h1000_0002);
    serve("rr2", 1, 32'hD000_0003);
    serve("rr3", 1, 32'h1000_0004);
    imem_valid = 1'b0;
    dmem_valid = 1'b0;

    // ---- 4: store ----
    dmem_addr  = 32'h8000_1004;
    dmem_wdata = 32'hDEAD_BEEF;
    dmem_mask  = 4'b0011;
    dmem_we    = 1'b1;
    dmem_valid = 1'b1;
    push_d(1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h8000_1004, 32'h0000_0000);
    serve("store", 2, 32'h0000_0000);
    dmem_valid = 1'b0;
    dmem_we    = 1'b0;
    dmem_mask  = 4'h5;
    dmem_wdata = 32'h1111_2222;

    // ---- 5: flush mid-transaction, pending D served next ----
    imem_addr  = 32'h0000_0300;
    imem_valid = 1'b1;
    push_i(32'h0000_0300, 32'h1000_0005);
    push_d(1'b0, 4'h5, 32'h1111_2222, 32'h0000_0400, 32'hD000_0006);
    tick();
    imem_valid = 1'b0;
    imem_addr  = 32'h0000_0999;
    dmem_addr  = 32'h0000_0400;
    dmem_valid = 1'b1;
    serve("flush", 2, 32'h1000_0005);
    serve("pend", 0, 32'hD000_0006);
    dmem_valid = 1'b0;

    // ---- 3: fixed D priority on instance b ----
    sel        = 1'b1;
    imem_addr  = 32'h0000_0500;
    dmem_addr  = 32'h0000_0600;
    imem_valid = 1'b1;
    dmem_valid = 1'b1;
    push_d(1'b0, 4'h5, 32'h1111_2222, 32'h0000_0600, 32'hD000_0007);
    push_d(1'b0, 4'h5, 32'h1111_2222, 32'h0000_0600, 32'hD000_0008);
    push_i(32'h0000_0500, 32'h1000_0009);
    serve("fix0", 1, 32'hD000_0007);
    serve("fix1", 1, 32'hD000_0008);
    dmem_valid = 1'b0;
    serve("fix2", 1, 32'h1000_0009);
    imem_valid = 1'b0;
    sel        = 1'b0;
    tick();

    // ---- 6: watchdog, async reset, late response ----
    imem_addr  = 32'h0000_0700;
    imem_valid = 1'b1;
    wd_iss     = {1'b0, 4'hF, 32'h0, 32'h0000_0700};
    tick();
    check("wd_bus", CW'({m_valid, m_we, m_mask, m_wdata, m_addr}), CW'({1'b1, wd_iss}));
    for (int k = 1; k <= 12; k++) begin
      check("wd_flag", CW'({m_valid, m_timeout}), CW'({1'b1, (k >= 9)}));
      tick();
    end
    imem_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", CW'({m_valid, m_we, m_mask, m_wdata, m_addr, m_timeout, m_iresp, m_dresp, m_dbg}), CW'(0));
    tick();
    rst_n     = 1'b1;
    mem_resp  = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("late_resp", CW'({m_iresp, m_dresp, m_irdata, m_drdata, m_valid}), CW'(0));
    tick();
    mem_resp  = 1'b0;
    mem_rdata = '0;
    check("post_rst", CW'({m_valid, m_timeout, m_dbg}), CW'(0));

    // ---- final report ----
    check("iss_q_left", CW'(iss_q.size()), CW'(0));
    check("exp_q_left", CW'(exp_q.size()), CW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
